// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constants for the UART receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Eight data bits plus one parity bit are shifted in per frame.
    localparam int FRAME_BITS = 9;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-interval tick generator (half or full bit period)
module uart_baud_counter #(
    parameter int BIT_TICKS = 5208
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic half_mode_i,
    output logic tick_o
);

    localparam int CW = $clog2(BIT_TICKS + 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_TICKS / 2 - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick_o = (count_q == (half_mode_i ? HALF_LAST : FULL_LAST));

    // The counter restarts on its own tick so consecutive intervals are exactly BIT_TICKS long.
    always_comb begin
        count_d = count_q + 1'b1;
        if (clear_i || tick_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - start/8 data/parity/stop serial receiver with mid-bit sampling
module uart_receiver
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       enable,
    input  logic       Rx,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic [8:0] working_data,
    output logic [3:0] bits_received,
    output logic       receiving
);

    localparam int BIT_TICKS = CLOCK_FREQ / BAUD_RATE;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    uart_state_t state_q, state_d;
    logic [8:0]  wd_q, wd_d;
    logic [3:0]  bits_q, bits_d;
    logic        recv_q, recv_d;
    logic [7:0]  dout_q, dout_d;
    logic        drdy_q, drdy_d;
    logic        tick;

    uart_baud_counter #(
        .BIT_TICKS(BIT_TICKS)
    ) u_baud (
        .clk_i      (clk),
        .rst_i      (nRst),
        .clear_i    ((state_q == IDLE) || !enable),
        .half_mode_i(state_q == START),
        .tick_o     (tick)
    );

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        bits_d  = bits_q;
        dout_d  = dout_q;
        drdy_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            bits_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!Rx) begin
                        state_d = START;
                        bits_d  = '0;
                        wd_d    = '0;
                    end
                end
                START: begin
                    if (tick) begin
                        state_d = Rx ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        wd_d   = {Rx, wd_q[8:1]};
                        bits_d = bits_q + 4'd1;
                        if (bits_q == LAST_BIT) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    // A low stop bit is a framing error: the byte is dropped silently.
                    if (tick) begin
                        if (Rx) begin
                            dout_d = wd_q[7:0];
                            drdy_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        recv_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            state_q <= IDLE;
            wd_q    <= '0;
            bits_q  <= '0;
            recv_q  <= 1'b0;
            dout_q  <= '0;
            drdy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            bits_q  <= bits_d;
            recv_q  <= recv_d;
            dout_q  <= dout_d;
            drdy_q  <= drdy_d;
        end
    end

    assign data_out      = dout_q;
    assign data_ready    = drdy_q;
    assign working_data  = wd_q;
    assign bits_received = bits_q;
    assign receiving     = recv_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int B = 17;
    localparam int H = B / 2;
    localparam int STOP_T = H + 10 * B;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       enable = 1'b1;
    logic       Rx = 1'b1;
    logic [7:0] data_out;
    logic       data_ready;
    logic [8:0] working_data;
    logic [3:0] bits_received;
    logic       receiving;

    int n_tests = 0;
    int n_fail  = 0;
    int idle_errs = 0;
    logic [7:0] exp_dout;

    always #5 clk = ~clk;

    uart_receiver #(
        .BAUD_RATE (1000),
        .CLOCK_FREQ(17000)
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .enable       (enable),
        .Rx           (Rx),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .working_data (working_data),
        .bits_received(bits_received),
        .receiving    (receiving)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one frame from the negedge before the start bit's first sample edge (t=0)
    // through t_end; each cycle compares receiving/bits_received/data_ready with the
    // values implied by mid-bit sampling at t = H + k*B.
    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stp,
                               input int t_end, output int errs);
        logic [10:0] fr;
        int exp_bits;
        logic exp_recv, exp_rdy;
        fr = {stp, par, d, 1'b0};
        errs = 0;
        for (int t = 0; t <= t_end; t++) begin
            Rx = fr[t / B];
            @(negedge clk);
            exp_bits = 0;
            for (int k = 0; k < 9; k++)
                if (H + B * (k + 1) <= t) exp_bits++;
            exp_recv = (t < STOP_T);
            exp_rdy  = stp && (t == STOP_T);
            if (receiving !== exp_recv || bits_received !== 4'(exp_bits) || data_ready !== exp_rdy)
                errs++;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int g = 0; g < n; g++) begin
            Rx = 1'b1;
            @(negedge clk);
            if (receiving !== 1'b0 || data_ready !== 1'b0) idle_errs++;
        end
    endtask

    task automatic full_frame(input string tag, input logic [7:0] d, input logic par,
                              input logic stp, input int t_end);
        int errs;
        drive_frame(d, par, stp, t_end, errs);
        if (stp) exp_dout = d;
        check_eq({tag, "_trace"}, 16'(errs), 16'd0);
        check_eq({tag, "_wdata"}, 16'(working_data), 16'({par, d}));
        check_eq({tag, "_dout"}, 16'(data_out), 16'(exp_dout));
    endtask

    initial begin
        int errs;
        logic [7:0] d;
        logic par, stp;
        int t_end;

        @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_wdata", 16'(working_data), 16'h0);
        check_eq("rst_bits", 16'(bits_received), 16'h0);
        check_eq("rst_recv", 16'(receiving), 16'h0);
        check_eq("rst_dout", 16'(data_out), 16'h0);
        check_eq("rst_rdy", 16'(data_ready), 16'h0);
        nRst = 1'b0;
        exp_dout = 8'h00;

        idle_cycles(200);
        check_eq("idle_persist", 16'({working_data, bits_received, data_out == 8'h0}), 16'h0001);

        full_frame("f0", 8'hF0, 1'b1, 1'b1, 11 * B - 1);
        check_eq("f0_wd9", 16'(working_data), 16'h1F0);

        // False start: low shorter than half a bit, then high.
        errs = 0;
        for (int t = 0; t < H + 4; t++) begin
            Rx = (t < 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (receiving !== (t < H) || data_ready !== 1'b0) errs++;
        end
        check_eq("false_start", 16'(errs), 16'd0);
        check_eq("false_bits", 16'(bits_received), 16'd0);

        full_frame("ferr", 8'hA5, 1'b0, 1'b0, STOP_T);
        idle_cycles(3);

        // Reset abort after four data bits.
        drive_frame(8'h5A, 1'b0, 1'b1, H + 4 * B + 1, errs);
        check_eq("abort_trace", 16'(errs), 16'd0);
        check_eq("abort_bits4", 16'(bits_received), 16'd4);
        Rx = 1'b1;
        nRst = 1'b1;
        @(negedge clk);
        nRst = 1'b0;
        exp_dout = 8'h00;
        check_eq("abort_state", 16'({working_data, bits_received, receiving, data_ready}), 16'h0);
        check_eq("abort_dout", 16'(data_out), 16'h0);
        idle_cycles(2);
        full_frame("x3c", 8'h3C, 1'b0, 1'b1, 11 * B - 1);

        // Enable drop mid-frame: progress cleared, data_out kept.
        drive_frame(8'h81, 1'b1, 1'b1, H + 6 * B + 2, errs);
        check_eq("en_trace", 16'(errs), 16'd0);
        Rx = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check_eq("en_state", 16'({bits_received, receiving, data_ready}), 16'h0);
        check_eq("en_dout", 16'(data_out), 16'(exp_dout));
        enable = 1'b1;
        idle_cycles(2);

        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom_range(0, 255));
            par = 1'($urandom_range(0, 1));
            stp = ($urandom_range(0, 3) != 0);
            t_end = (stp && $urandom_range(0, 1) == 1) ? 11 * B - 1 : STOP_T;
            full_frame($sformatf("rnd%0d", i), d, par, stp, t_end);
            idle_cycles(stp ? $urandom_range(0, 3) : $urandom_range(1, 3));
        end

        check_eq("idle_gaps", 16'(idle_errs), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Asynchronous serial receiver, 8N1-style framing extended with one parity bit: start bit, 8 data bits LSB first, 1 parity bit, 1 stop bit.
- Oversamples the Rx line using the system clock, with sampling at mid-bit.
- Presents the received byte on data_out with a one-cycle data_ready strobe.
- Exposes internal progress (working_data, bits_received, receiving) for debug and verification.
- Sits between the board UART pin and the CPU's I/O register block.

Parameters:
- BAUD_RATE, 9600, serial bit rate in bits/s.
- CLOCK_FREQ, 50000000, clk frequency in Hz.
- Derived constants:
  - BIT_TICKS = CLOCK_FREQ/BAUD_RATE (integer division; 5208 at defaults).
  - HALF_TICKS = BIT_TICKS/2 (2604 at defaults).

Ports:
- clk  in  1  system clock, rising-edge active.
- nRst  in  1  reset; synchronous, active-high (asserted = 1), despite the name.
- enable  in  1  receiver enable; 0 forces IDLE.
- Rx  in  1  serial input; idle high. Sampled directly, so the integrator supplies any synchronizer.
- data_out  out  8  last successfully received byte.
- data_ready  out  1  one-cycle pulse when data_out updates.
- working_data  out  9  shift register: {parity, data[7:0]} being assembled.
- bits_received  out  4  count of data and parity bits captured in the current frame (0..9).
- receiving  out  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- All state and outputs are registered.
- Reset (nRst=1 at a rising edge): state=IDLE, tick counter=0, working_data=0, bits_received=0, receiving=0, data_out=0, data_ready=0. Reset mid-frame aborts the frame.
- enable=0 at a rising edge: return to IDLE and clear tick counter, bits_received and receiving. data_out is held.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - If Rx=0 and enable=1 at an edge, go to START, set receiving=1 (visible after that same edge, i.e. 1-cycle latency), clear counter, bits_received and working_data.
  - Otherwise receiving stays 0.
- START:
  - Count HALF_TICKS cycles, then sample Rx.
  - If Rx=0, go to DATA with counter cleared.
  - If Rx=1 (glitch), return to IDLE with receiving=0.
- DATA:
  - Every BIT_TICKS cycles (mid-bit), shift right: working_data <= {Rx, working_data[8:1]}, and bits_received += 1.
  - After the 9th capture (bits_received=9), go to STOP with counter cleared.
  - Resulting layout: working_data[7:0] = data (first received bit in bit 0), working_data[8] = parity bit.
- STOP:
  - After BIT_TICKS cycles, sample Rx.
  - If 1: data_out <= working_data[7:0] and data_ready=1 for exactly one cycle.
  - If 0 (framing error): frame discarded; data_out and data_ready are unchanged.
  - Either way go to IDLE with receiving=0.
- The parity bit is captured but not checked; no error output.
- working_data and bits_received hold their final values in IDLE until the next start bit.
- data_ready is 0 at all other times. data_out holds its value between frames.
- Tick counter width is $clog2(BIT_TICKS+1). The counter compares against BIT_TICKS-1, so each interval is exactly BIT_TICKS cycles.
- Back-to-back frames: a new start bit is accepted on the first IDLE cycle after STOP.

Decomposition:
- Shared package uart_pkg: state enum (IDLE, START, DATA, STOP); FRAME_BITS=9 constant.
- One natural sub-module, uart_baud_counter:
  - Parameterised by BIT_TICKS.
  - Inputs: clear, half_mode.
  - Outputs: a tick pulse at HALF_TICKS or BIT_TICKS.
- The FSM and shift register live in the top.

Test Plan:
- Reset: hold nRst=1 for 2 cycles -> working_data=0, bits_received=0, receiving=0, data_out=0, data_ready=0; all values persist after release.
- Idle line: Rx=1 for 9600 cycles -> receiving=0 throughout; no data_ready.
- Full frame at defaults (5208 cycles/bit):
  - Stimulus: start 0; data bits 0,0,0,0,1,1,1,1; parity 1; stop 1.
  - Required response:
    - receiving=1 one cycle after Rx falls.
    - bits_received increments at mid-bit, ending at 9.
    - working_data=9'h1F0.
    - data_out=8'hF0 with a single-cycle data_ready.
    - receiving=0 afterwards.
- False start: Rx low for 1000 cycles then high -> receiving drops at the half-bit check; bits_received=0; no data_ready.
- Framing error: frame carrying 8'hA5 with stop bit 0 -> working_data[7:0]=8'hA5; data_out keeps its previous value; no data_ready.
- Abort: assert nRst (or drop enable) after 4 data bits -> all outputs at reset/idle values next cycle; a following frame carrying 8'h3C is received correctly.
